// File: rtl/sad_acc.sv
// Sum-of-absolute-differences accumulator: per-sample |A-B| plus a LEN-sample block SAD
// with valid/ready handshakes on input and on the block result.
module sad_acc #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LEN    = 4,
  parameter int unsigned SIGNED = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic [WIDTH-1:0]                aIn,
  input  logic [WIDTH-1:0]                bIn,
  output logic [WIDTH-1:0]                difOut,
  output logic                            difValid,
  output logic [WIDTH+$clog2(LEN)-1:0]    sadOut,
  output logic                            sadValid,
  input  logic                            sadReady
);

  localparam int unsigned SW = WIDTH + $clog2(LEN);
  localparam int unsigned CW = $clog2(LEN);
  localparam logic [CW-1:0] LastCnt = CW'(LEN - 1);

  typedef enum logic {StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dif_q, dif_d;
  logic             dif_valid_q, dif_valid_d;
  logic [SW-1:0]    sad_q, sad_d;
  logic             sad_valid_q, sad_valid_d;

  logic signed [WIDTH:0] a_x, b_x;
  logic [WIDTH-1:0]      dif;
  logic [SW-1:0]         dif_ext;
  logic                  accept;

  // One extra bit makes the compare and subtract exact in both signed and unsigned modes.
  always_comb begin
    if (SIGNED != 0) begin
      a_x = {aIn[WIDTH-1], aIn};
      b_x = {bIn[WIDTH-1], bIn};
    end else begin
      a_x = {1'b0, aIn};
      b_x = {1'b0, bIn};
    end
    dif     = (a_x >= b_x) ? WIDTH'(a_x - b_x) : WIDTH'(b_x - a_x);
    dif_ext = {{(SW - WIDTH){1'b0}}, dif};
  end

  assign inReady = (state_q == StAcc) && !clear;
  assign accept  = inValid && inReady;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dif_d       = dif_q;
    dif_valid_d = 1'b0;
    sad_d       = sad_q;
    sad_valid_d = sad_valid_q;
    unique case (state_q)
      StAcc: begin
        if (clear) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          dif_d       = dif;
          dif_valid_d = 1'b1;
          if (cnt_q == LastCnt) begin
            sad_d       = acc_q + dif_ext;
            sad_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            state_d     = StHold;
          end else begin
            acc_d = acc_q + dif_ext;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        // sadValid is always set in this state, so a take needs only sadReady.
        if (sadReady) begin
          sad_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      cnt_q       <= '0;
      dif_q       <= '0;
      dif_valid_q <= 1'b0;
      sad_q       <= '0;
      sad_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dif_q       <= dif_d;
      dif_valid_q <= dif_valid_d;
      sad_q       <= sad_d;
      sad_valid_q <= sad_valid_d;
    end
  end

  assign difOut   = dif_q;
  assign difValid = dif_valid_q;
  assign sadOut   = sad_q;
  assign sadValid = sad_valid_q;

endmodule
